rename_unit: RTL and testbench
==============================

RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 Parameter NUM_AREGS, default 32: architectural registers; AREG_W = log2(NUM_AREGS).
REQ-002 Parameter TAG_W, default 6: tag width; NUM_TAGS = 2**TAG_W.
REQ-003 Parameter NUM_CKPT, default 4: branch checkpoints (power of 2); CKPT_W = log2(NUM_CKPT).
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ren_valid  in  1  rename request.
- ren_rd_we  in  1  instruction writes rd.
- ren_is_branch  in  1  instruction needs a checkpoint.
- ren_rd, ren_rs1, ren_rs2  in  AREG_W  architectural addresses.
- ren_ready  out  1  request accepted this cycle.
- ren_rd_tag  out  TAG_W  allocated tag.
- rs1_tag, rs2_tag  out  TAG_W  source tags.
- rs1_pending, rs2_pending  out  1  source not yet produced.
- ren_ckpt_id  out  CKPT_W  checkpoint slot given to a branch.
- cdb_valid  in  1  completion broadcast.
- cdb_tag  in  TAG_W  completing tag.
- regfile_we  out  1  architectural write enable.
- regfile_waddr  out  AREG_W  architectural write address.
- br_resolve_valid  in  1  oldest branch resolved.
- br_mispredict  in  1  resolved branch was mispredicted.
- free_count  out  TAG_W+1  free tags.

Function
REQ-005 fire = ren_valid & ren_ready; alloc = fire & ren_rd_we & (ren_rd != 0).
REQ-006 ren_ready = (free_count != 0) & ~(br_resolve_valid & br_mispredict) & (~ren_is_branch | checkpoint slot free).
REQ-007 Free list: circular FIFO of NUM_TAGS entries, filled with tags 0..NUM_TAGS-1 in order at reset.
- Pop on alloc; ren_rd_tag = head entry, combinational.
- Push cdb_tag on cdb_valid.
- Simultaneous push and pop both occur; count unchanged.
- A push when full is ignored and flagged by an assertion.
REQ-008 Rename table: per areg {valid, tag}.
- Sources read the table before this cycle's update, so rd == rs returns the old mapping.
- Areg 0 always returns pending=0, tag=0 and is never written.
REQ-009 CDB bypass: rsX_pending = entry.valid & ~(cdb_valid & cdb_tag == entry.tag).
REQ-010 On alloc, table[ren_rd] <= {1, ren_rd_tag} at the next edge.
REQ-011 On cdb_valid, the entry with valid=1 and tag==cdb_tag (at most one) is cleared. regfile_we=1 and regfile_waddr=that areg, combinationally, same cycle.
- No match gives regfile_we=0.
- If alloc targets the same areg in the same cycle, the new mapping wins; regfile_we is still asserted.
REQ-012 Checkpoints are a FIFO of NUM_CKPT slots (head = oldest, tail = next free, count). A fire with ren_is_branch stores the post-update table plus the post-pop free-list read pointer into slot tail, and drives ren_ckpt_id = tail.
REQ-013 Every stored checkpoint applies the REQ-011 valid clear on each cdb_valid.
REQ-014 br_resolve_valid always refers to the checkpoint at head.
- With br_mispredict=0: release head only.
- With br_resolve_valid=0: no checkpoint action.
REQ-015 Mispredict (br_resolve_valid & br_mispredict), at the next edge:
- Table <= head checkpoint with this cycle's CDB clear applied.
- Free-list read pointer <= saved pointer.
- free_count <= NUM_TAGS minus tags still outstanding that were allocated before the branch, including this cycle's push.
- All checkpoints are released.
REQ-016 The environment guarantees that squashed instructions never broadcast on the CDB; REQ-015 relies on this.
REQ-017 A fire with ren_is_branch in the cycle its slot is released is not possible, by REQ-006.

Reset
REQ-018 While rst=0, the following are forced asynchronously and held until the first edge after release:
- Table all valid=0.
- Free list full, read pointer=0.
- free_count=NUM_TAGS; checkpoint count=0, head=tail=0.
- Outputs: ren_ready=1, regfile_we=0, all tags 0, ren_ckpt_id=0.
REQ-019 Reset asserted mid-mispredict or mid-allocation discards all state with no partial update.

Structure
REQ-020 A shared package holds NUM_AREGS, TAG_W, NUM_CKPT defaults and typedef rat_entry_t {valid, tag}.
REQ-021 The free list is sub-module tag_freelist, with push, pop, pointer save and pointer restore ports.

Verification
REQ-022 After reset, rename x5 <- x1 + x2 -> ren_rd_tag=0, rs pending=0, free_count=63; next cycle x6 <- x5 -> rs1_tag=0, rs1_pending=1.
REQ-023 A fire reading x5 while cdb_tag=0 is valid in the same cycle -> rs1_pending=0, regfile_we=1, regfile_waddr=5, free_count unchanged (push plus pop).
REQ-024 64 allocations with no CDB -> free_count=0, ren_ready=0; one cdb_tag=3 -> ren_ready=1; next allocation gets tag 3.
REQ-025 Branch checkpoint at tag 10, three more allocations (x7, x8, x9), then mispredict -> x7..x9 mappings reverted, next ren_rd_tag=11, free_count restored.
REQ-026 Four branches outstanding -> ren_ready=0 for a branch but 1 for a non-branch; a correct resolve frees slot 0 and the next branch gets ren_ckpt_id=0.

Source files
------------

// File: rtl/rename_unit_pkg.sv
// Shared defaults and types for the register rename unit.
package rename_unit_pkg;

    localparam int DEF_NUM_AREGS = 32;
    localparam int DEF_TAG_W     = 6;
    localparam int DEF_NUM_CKPT  = 4;
    localparam int DEF_AREG_W    = $clog2(DEF_NUM_AREGS);
    localparam int DEF_CKPT_W    = $clog2(DEF_NUM_CKPT);

    // One rename-table entry: valid means the value is still being produced
    // by the instruction that owns 'tag'.
    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
    } rat_entry_t;

    // Completion clear: an entry waiting on the broadcast tag becomes ready.
    function automatic rat_entry_t cdb_clear(input rat_entry_t e,
                                             input logic cdb_valid,
                                             input logic [DEF_TAG_W-1:0] cdb_tag);
        rat_entry_t r;
        r = e;
        if (cdb_valid && e.valid && (e.tag == cdb_tag)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rename_unit_if.sv
// Rename request, completion broadcast, branch resolve and status signals.
interface rename_unit_if
    import rename_unit_pkg::*;
#(
    parameter int AREG_W = DEF_AREG_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int CKPT_W = DEF_CKPT_W
);

    // Rename request and response
    logic              ren_valid;
    logic              ren_rd_we;
    logic              ren_is_branch;
    logic [AREG_W-1:0] ren_rd;
    logic [AREG_W-1:0] ren_rs1;
    logic [AREG_W-1:0] ren_rs2;
    logic              ren_ready;
    logic [TAG_W-1:0]  ren_rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
    logic              rs1_pending;
    logic              rs2_pending;
    logic [CKPT_W-1:0] ren_ckpt_id;

    // Completion broadcast and architectural writeback
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic              regfile_we;
    logic [AREG_W-1:0] regfile_waddr;

    // Branch resolution and status
    logic              br_resolve_valid;
    logic              br_mispredict;
    logic [TAG_W:0]    free_count;

    modport master (
        output ren_valid, ren_rd_we, ren_is_branch, ren_rd, ren_rs1, ren_rs2,
        output cdb_valid, cdb_tag, br_resolve_valid, br_mispredict,
        input  ren_ready, ren_rd_tag, rs1_tag, rs2_tag, rs1_pending, rs2_pending,
        input  ren_ckpt_id, regfile_we, regfile_waddr, free_count
    );

    modport slave (
        input  ren_valid, ren_rd_we, ren_is_branch, ren_rd, ren_rs1, ren_rs2,
        input  cdb_valid, cdb_tag, br_resolve_valid, br_mispredict,
        output ren_ready, ren_rd_tag, rs1_tag, rs2_tag, rs1_pending, rs2_pending,
        output ren_ckpt_id, regfile_we, regfile_waddr, free_count
    );

endinterface

// File: rtl/tag_freelist.sv
// Circular FIFO of free physical tags with checkpointable read pointer.
// Pointers carry one extra wrap bit so the occupancy is a plain difference
// and a restored read pointer yields the correct count without extra state.
module tag_freelist
    import rename_unit_pkg::*;
#(
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_push_tag,
    input  logic             i_pop,
    output logic [TAG_W-1:0] o_head_tag,
    output logic [TAG_W:0]   o_save_ptr,
    input  logic             i_restore,
    input  logic [TAG_W:0]   i_restore_ptr,
    output logic [TAG_W:0]   o_count
);

    localparam int             NUM_TAGS   = 2**TAG_W;
    localparam logic [TAG_W:0] FULL_COUNT = {1'b1, {TAG_W{1'b0}}};

    logic [TAG_W-1:0] r_mem [NUM_TAGS];
    logic [TAG_W:0]   r_rd_ptr;
    logic [TAG_W:0]   r_wr_ptr;
    logic [TAG_W:0]   w_count;
    logic             w_push_ok;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_push_ok  = i_push && (w_count != FULL_COUNT);
    assign o_count    = w_count;
    assign o_head_tag = r_mem[r_rd_ptr[TAG_W-1:0]];
    // Read pointer as it will be after this cycle's pop; a checkpoint taken
    // now must not hand out the tag just consumed.
    assign o_save_ptr = r_rd_ptr + (TAG_W+1)'(i_pop);

    // Storage and pointers: push at tail, pop or restore at head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this memory is reset on purpose -- it must come up holding
            // every tag once; plain storage elsewhere is left unreset.
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_mem[i] <= TAG_W'(i);
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= FULL_COUNT;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the
            // pre-edge pointer values regardless of statement order.
            if (w_push_ok) begin
                r_mem[r_wr_ptr[TAG_W-1:0]] <= i_push_tag;
            end
            r_wr_ptr <= r_wr_ptr + (TAG_W+1)'(w_push_ok);
            r_rd_ptr <= i_restore ? i_restore_ptr : o_save_ptr;
        end
    end

    // A completing tag can never find the list already full.
    a_push_not_full: assert property (
        @(posedge clk) disable iff (!rst) i_push |-> (w_count != FULL_COUNT)
    );

endmodule

// File: rtl/rename_unit.sv
// Register rename unit: rename table, tag free list, completion clearing
// and a FIFO of branch checkpoints for misprediction recovery.
module rename_unit
    import rename_unit_pkg::*;
#(
    parameter int NUM_AREGS = DEF_NUM_AREGS,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int NUM_CKPT  = DEF_NUM_CKPT
) (
    input  logic         clk,
    input  logic         rst,
    rename_unit_if.slave bus
);

    localparam int              AREG_W    = $clog2(NUM_AREGS);
    localparam int              CKPT_W    = $clog2(NUM_CKPT);
    localparam logic [CKPT_W:0] CKPT_FULL = (CKPT_W+1)'(NUM_CKPT);

    // Handshake
    logic              w_mispredict;
    logic              w_resolve_ok;
    logic              w_ckpt_free;
    logic              w_ready;
    logic              w_fire;
    logic              w_alloc;
    logic              w_br_fire;

    // Free list
    logic [TAG_W-1:0]  w_head_tag;
    logic [TAG_W:0]    w_save_ptr;
    logic [TAG_W:0]    w_free_count;

    // Completion match in the live table
    logic              w_cdb_hit;
    logic [AREG_W-1:0] w_cdb_areg;

    // Source lookup
    rat_entry_t        w_rs1_ent;
    rat_entry_t        w_rs2_ent;
    rat_entry_t        w_rs1_byp;
    rat_entry_t        w_rs2_byp;

    // Rename table and checkpoints
    rat_entry_t        r_table      [NUM_AREGS];
    rat_entry_t        w_table_next [NUM_AREGS];
    rat_entry_t        w_restore    [NUM_AREGS];
    rat_entry_t        r_ckpt_table [NUM_CKPT][NUM_AREGS];
    logic [TAG_W:0]    r_ckpt_ptr   [NUM_CKPT];
    logic [CKPT_W-1:0] r_ckpt_head;
    logic [CKPT_W-1:0] r_ckpt_tail;
    logic [CKPT_W:0]   r_ckpt_count;

    assign w_mispredict = bus.br_resolve_valid & bus.br_mispredict;
    assign w_resolve_ok = bus.br_resolve_valid & ~bus.br_mispredict;
    assign w_ckpt_free  = (r_ckpt_count != CKPT_FULL);

    // Requests stall while out of tags, during recovery, or for a branch
    // when no checkpoint slot is left.
    assign w_ready   = (w_free_count != '0) & ~w_mispredict
                     & (~bus.ren_is_branch | w_ckpt_free);
    assign w_fire    = bus.ren_valid & w_ready;
    assign w_alloc   = w_fire & bus.ren_rd_we & (bus.ren_rd != '0);
    assign w_br_fire = w_fire & bus.ren_is_branch;

    tag_freelist #(
        .TAG_W (TAG_W)
    ) u_freelist (
        .clk           (clk),
        .rst           (rst),
        .i_push        (bus.cdb_valid),
        .i_push_tag    (bus.cdb_tag),
        .i_pop         (w_alloc),
        .o_head_tag    (w_head_tag),
        .o_save_ptr    (w_save_ptr),
        .i_restore     (w_mispredict),
        .i_restore_ptr (r_ckpt_ptr[r_ckpt_head]),
        .o_count       (w_free_count)
    );

    // Sources read the pre-update table; x0 is hard-wired to a ready tag 0.
    assign w_rs1_ent = (bus.ren_rs1 == '0) ? '0 : r_table[bus.ren_rs1];
    assign w_rs2_ent = (bus.ren_rs2 == '0) ? '0 : r_table[bus.ren_rs2];
    assign w_rs1_byp = cdb_clear(w_rs1_ent, bus.cdb_valid, bus.cdb_tag);
    assign w_rs2_byp = cdb_clear(w_rs2_ent, bus.cdb_valid, bus.cdb_tag);

    assign bus.ren_ready   = w_ready;
    assign bus.ren_rd_tag  = w_head_tag;
    assign bus.rs1_tag     = w_rs1_ent.tag;
    assign bus.rs2_tag     = w_rs2_ent.tag;
    assign bus.rs1_pending = w_rs1_byp.valid;
    assign bus.rs2_pending = w_rs2_byp.valid;
    assign bus.ren_ckpt_id = r_ckpt_tail;
    assign bus.free_count  = w_free_count;

    // Find the architectural register whose live mapping just completed.
    always_comb begin
        // NOTE: defaults before the loop so no path leaves an output
        // unassigned and no latch is inferred.
        w_cdb_hit  = 1'b0;
        w_cdb_areg = '0;
        for (int i = 1; i < NUM_AREGS; i++) begin
            if (!w_cdb_hit && bus.cdb_valid && r_table[i].valid
                && (r_table[i].tag == bus.cdb_tag)) begin
                w_cdb_hit  = 1'b1;
                w_cdb_areg = AREG_W'(i);
            end
        end
    end

    assign bus.regfile_we    = w_cdb_hit;
    assign bus.regfile_waddr = w_cdb_areg;

    // Next table on the normal path: completion clear, then the new mapping,
    // which wins when both target the same register.
    always_comb begin
        for (int i = 0; i < NUM_AREGS; i++) begin
            w_table_next[i] = cdb_clear(r_table[i], bus.cdb_valid, bus.cdb_tag);
            if (w_alloc && (bus.ren_rd == AREG_W'(i))) begin
                w_table_next[i].valid = 1'b1;
                w_table_next[i].tag   = w_head_tag;
            end
        end
        w_table_next[0] = '0;
    end

    // Recovery image: oldest checkpoint with this cycle's completion applied.
    always_comb begin
        for (int i = 0; i < NUM_AREGS; i++) begin
            w_restore[i] = cdb_clear(r_ckpt_table[r_ckpt_head][i],
                                     bus.cdb_valid, bus.cdb_tag);
        end
        w_restore[0] = '0;
    end

    // Live rename table: normal update or rollback on mispredict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                r_table[i] <= w_mispredict ? w_restore[i] : w_table_next[i];
            end
        end
    end

    // Checkpoint storage: capture at tail on a branch, keep every stored
    // copy current with completions. Contents are only meaningful while
    // counted, so they need no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (w_br_fire && (r_ckpt_tail == CKPT_W'(s))) begin
                for (int i = 0; i < NUM_AREGS; i++) begin
                    r_ckpt_table[s][i] <= w_table_next[i];
                end
                r_ckpt_ptr[s] <= w_save_ptr;
            end else begin
                for (int i = 0; i < NUM_AREGS; i++) begin
                    r_ckpt_table[s][i] <= cdb_clear(r_ckpt_table[s][i],
                                                    bus.cdb_valid, bus.cdb_tag);
                end
            end
        end
    end

    // Checkpoint FIFO bookkeeping: allocate at tail, release at head,
    // flush everything on a mispredict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ckpt_head  <= '0;
            r_ckpt_tail  <= '0;
            r_ckpt_count <= '0;
        end else if (w_mispredict) begin
            r_ckpt_head  <= '0;
            r_ckpt_tail  <= '0;
            r_ckpt_count <= '0;
        end else begin
            if (w_br_fire) begin
                r_ckpt_tail <= r_ckpt_tail + 1'b1;
            end
            if (w_resolve_ok) begin
                r_ckpt_head <= r_ckpt_head + 1'b1;
            end
            r_ckpt_count <= r_ckpt_count + (CKPT_W+1)'(w_br_fire)
                          - (CKPT_W+1)'(w_resolve_ok);
        end
    end

    // A resolve always refers to an outstanding branch.
    a_resolve_has_ckpt: assert property (
        @(posedge clk) disable iff (!rst) bus.br_resolve_valid |-> (r_ckpt_count != '0)
    );

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit with a scoreboard queue and a negedge monitor.
module tb_rename_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rename_unit_if bus ();

    rename_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int M_RDY = 0, M_TAG = 1, M_RS1 = 2, M_RS2 = 3, M_CK = 4, M_WE = 5, M_FC = 6;

    typedef struct {
        string    name;
        bit [6:0] mask;
        int       rdy, tag, rs1_tag, rs1_p, rs2_tag, rs2_p, ck, we, waddr, fc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expectation builders
    function automatic exp_t ex(input string n);
        exp_t e;
        e.name = n; e.mask = '0; e.rdy = 0; e.tag = 0; e.rs1_tag = 0; e.rs1_p = 0;
        e.rs2_tag = 0; e.rs2_p = 0; e.ck = 0; e.we = 0; e.waddr = 0; e.fc = 0;
        return e;
    endfunction
    function automatic exp_t x_rdy(input exp_t e, input int v);
        e.mask[M_RDY] = 1'b1; e.rdy = v; return e;
    endfunction
    function automatic exp_t x_tag(input exp_t e, input int v);
        e.mask[M_TAG] = 1'b1; e.tag = v; return e;
    endfunction
    function automatic exp_t x_rs1(input exp_t e, input int t, input int p);
        e.mask[M_RS1] = 1'b1; e.rs1_tag = t; e.rs1_p = p; return e;
    endfunction
    function automatic exp_t x_rs2(input exp_t e, input int t, input int p);
        e.mask[M_RS2] = 1'b1; e.rs2_tag = t; e.rs2_p = p; return e;
    endfunction
    function automatic exp_t x_ck(input exp_t e, input int v);
        e.mask[M_CK] = 1'b1; e.ck = v; return e;
    endfunction
    function automatic exp_t x_we(input exp_t e, input int we, input int a);
        e.mask[M_WE] = 1'b1; e.we = we; e.waddr = a; return e;
    endfunction
    function automatic exp_t x_fc(input exp_t e, input int v);
        e.mask[M_FC] = 1'b1; e.fc = v; return e;
    endfunction

    // Input drivers
    task automatic idle();
        bus.ren_valid = 1'b0; bus.ren_rd_we = 1'b0; bus.ren_is_branch = 1'b0;
        bus.ren_rd = '0; bus.ren_rs1 = '0; bus.ren_rs2 = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0;
        bus.br_resolve_valid = 1'b0; bus.br_mispredict = 1'b0;
    endtask

    task automatic ren(input bit v, input bit we, input bit br, input int rd, input int rs1, input int rs2);
        bus.ren_valid = v; bus.ren_rd_we = we; bus.ren_is_branch = br;
        bus.ren_rd = rd[4:0]; bus.ren_rs1 = rs1[4:0]; bus.ren_rs2 = rs2[4:0];
    endtask

    task automatic cdb(input bit v, input int t);
        bus.cdb_valid = v; bus.cdb_tag = t[5:0];
    endtask

    task automatic brr(input bit v, input bit mp);
        bus.br_resolve_valid = v; bus.br_mispredict = mp;
    endtask

    // One clock with an expectation handed to the monitor.
    task automatic step(input exp_t e);
        sb_q.push_back(e);
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        idle();
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        idle(); rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL sb_empty: got 0 queued expected 1");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.mask[M_RDY]) check({mon_e.name, ".ready"}, int'(bus.ren_ready), mon_e.rdy);
                if (mon_e.mask[M_TAG]) check({mon_e.name, ".rd_tag"}, int'(bus.ren_rd_tag), mon_e.tag);
                if (mon_e.mask[M_RS1]) begin
                    check({mon_e.name, ".rs1_tag"}, int'(bus.rs1_tag), mon_e.rs1_tag);
                    check({mon_e.name, ".rs1_pend"}, int'(bus.rs1_pending), mon_e.rs1_p);
                end
                if (mon_e.mask[M_RS2]) begin
                    check({mon_e.name, ".rs2_tag"}, int'(bus.rs2_tag), mon_e.rs2_tag);
                    check({mon_e.name, ".rs2_pend"}, int'(bus.rs2_pending), mon_e.rs2_p);
                end
                if (mon_e.mask[M_CK]) check({mon_e.name, ".ckpt_id"}, int'(bus.ren_ckpt_id), mon_e.ck);
                if (mon_e.mask[M_WE]) begin
                    check({mon_e.name, ".rf_we"}, int'(bus.regfile_we), mon_e.we);
                    if (mon_e.we != 0) check({mon_e.name, ".rf_waddr"}, int'(bus.regfile_waddr), mon_e.waddr);
                end
                if (mon_e.mask[M_FC]) check({mon_e.name, ".free_cnt"}, int'(bus.free_count), mon_e.fc);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b0;
        tick();

        // Reset state
        ren(0, 0, 0, 0, 3, 0);
        step(x_fc(x_we(x_ck(x_rs1(x_tag(x_rdy(ex("reset"), 1), 0), 0, 0), 0), 0, 0), 64));
        rst = 1'b1;

        // Basic renaming and dependency
        ren(1, 1, 0, 5, 1, 2);
        step(x_fc(x_we(x_rs2(x_rs1(x_tag(x_rdy(ex("x5"), 1), 0), 0, 0), 0, 0), 0, 0), 64));
        ren(1, 1, 0, 6, 5, 0);
        step(x_fc(x_rs2(x_rs1(x_tag(ex("x6"), 1), 0, 1), 0, 0), 63));
        // Same-cycle completion bypass on a read source
        ren(1, 1, 0, 7, 5, 6); cdb(1, 0);
        step(x_fc(x_we(x_rs2(x_rs1(x_tag(ex("bypass"), 2), 0, 0), 1, 1), 1, 5), 62));
        // rd == rs1 reads the old (now ready) mapping
        ren(1, 1, 0, 5, 5, 7);
        step(x_fc(x_we(x_rs2(x_rs1(x_tag(ex("rd_eq_rs"), 3), 0, 0), 2, 1), 0, 0), 62));
        ren(1, 1, 0, 6, 6, 0);
        step(x_fc(x_rs1(x_tag(ex("remap_x6"), 4), 1, 1), 61));
        // Completion of a tag no longer mapped: no architectural write
        cdb(1, 1);
        step(x_fc(x_we(ex("stale_cdb"), 0, 0), 60));
        // Writes to x0 consume no tag
        ren(1, 1, 0, 0, 0, 0);
        step(x_fc(x_rs1(x_tag(x_rdy(ex("rd_x0"), 1), 5), 0, 0), 61));
        ren(1, 1, 0, 8, 0, 0);
        step(x_fc(x_tag(ex("x8"), 5), 61));
        // Allocation and completion on the same register: new mapping wins
        ren(1, 1, 0, 8, 8, 0); cdb(1, 5);
        step(x_fc(x_we(x_rs1(x_tag(ex("same_areg"), 6), 5, 0), 1, 8), 60));
        ren(1, 0, 0, 0, 8, 0);
        step(x_fc(x_rs1(x_tag(ex("same_areg_nx"), 7), 6, 1), 60));

        // Exhaust the free list
        do_reset();
        for (int i = 0; i < 64; i++) begin
            ren(1, 1, 0, (i % 31) + 1, 0, 0);
            step(x_fc(x_tag(x_rdy(ex("fill"), 1), i), 64 - i));
        end
        ren(1, 1, 0, 1, 0, 0);
        step(x_fc(x_rdy(ex("empty"), 0), 0));
        ren(1, 1, 0, 1, 0, 0); cdb(1, 3);
        step(x_we(x_fc(x_rdy(ex("empty_cdb"), 0), 0), 0, 0));
        ren(1, 1, 0, 1, 0, 0);
        step(x_fc(x_tag(x_rdy(ex("refill"), 1), 3), 1));
        ren(1, 1, 0, 2, 0, 0);
        step(x_fc(x_rdy(ex("empty_again"), 0), 0));

        // Branch checkpoint and mispredict recovery
        do_reset();
        for (int i = 0; i < 10; i++) begin
            ren(1, 1, 0, i + 1, 0, 0);
            step(x_fc(x_tag(ex("pre_br"), i), 64 - i));
        end
        ren(1, 1, 1, 11, 1, 0);
        step(x_fc(x_rs1(x_ck(x_tag(x_rdy(ex("branch"), 1), 10), 0), 0, 1), 54));
        ren(1, 1, 0, 7, 7, 11); cdb(1, 1);
        step(x_fc(x_we(x_ck(x_rs2(x_rs1(x_tag(ex("post_x7"), 11), 6, 1), 10, 1), 1), 1, 2), 53));
        ren(1, 1, 0, 8, 7, 0);
        step(x_fc(x_rs1(x_tag(ex("post_x8"), 12), 11, 1), 53));
        ren(1, 1, 0, 9, 0, 0);
        step(x_fc(x_tag(ex("post_x9"), 13), 52));
        ren(1, 1, 0, 12, 0, 0); brr(1, 1); cdb(1, 0);
        step(x_fc(x_we(x_tag(x_rdy(ex("mispredict"), 0), 14), 1, 1), 51));
        ren(1, 1, 0, 12, 7, 2);
        step(x_fc(x_ck(x_rs2(x_rs1(x_tag(x_rdy(ex("recovered"), 1), 11), 6, 1), 1, 0), 0), 55));
        ren(1, 0, 0, 0, 8, 9);
        step(x_fc(x_rs2(x_rs1(x_tag(ex("recov_x8x9"), 12), 7, 1), 8, 1), 54));
        ren(1, 0, 0, 0, 1, 11);
        step(x_rs2(x_rs1(ex("recov_x1x11"), 0, 0), 10, 1));

        // Checkpoint slots exhausted, then freed by a correct resolve
        for (int k = 0; k < 4; k++) begin
            ren(1, 0, 1, 0, 0, 0);
            step(x_ck(x_rdy(ex("br_fill"), 1), k));
        end
        ren(1, 0, 1, 0, 0, 0);
        step(x_fc(x_ck(x_rdy(ex("br_full"), 0), 0), 54));
        ren(1, 0, 0, 0, 0, 0);
        step(x_rdy(ex("nonbr_full"), 1));
        ren(1, 0, 1, 0, 0, 0); brr(1, 0);
        step(x_rdy(ex("br_on_release"), 0));
        ren(1, 0, 1, 0, 0, 0);
        step(x_ck(x_rdy(ex("br_slot0"), 1), 0));
        brr(1, 1);
        step(x_rdy(ex("mp_slot1"), 0));
        ren(1, 0, 1, 0, 12, 0);
        step(x_fc(x_ck(x_rs1(x_rdy(ex("after_mp2"), 1), 11, 1), 0), 54));

        // Asynchronous reset in the middle of an allocation
        ren(1, 1, 0, 9, 12, 0);
        #2 rst = 1'b0;
        step(x_fc(x_we(x_ck(x_rs1(x_tag(x_rdy(ex("async_rst"), 1), 0), 0, 0), 0), 0, 0), 64));
        rst = 1'b1;

        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
